// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 hex keypad scanner.
// Physical position index is 4*row + col; KEY_MAP turns it into the hex key number.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Entry 15 is listed first; rows read r3 .. r0, columns c3 .. c0.
    localparam logic [15:0][3:0] KEY_MAP = '{
        4'hF, 4'hB, 4'h0, 4'hA,
        4'hE, 4'h9, 4'h8, 4'h7,
        4'hD, 4'h6, 4'h5, 4'h4,
        4'hC, 4'h3, 4'h2, 4'h1
    };

    typedef enum logic [1:0] {
        DRIVE  = 2'd0,
        SAMPLE = 2'd1,
        COMMIT = 2'd2
    } scan_state_t;

endpackage

// File: rtl/key_debounce.sv
// Single-key debounce cell: holds the stable state and a 4-bit disagreement counter,
// updated only on frame commit. stable_next exposes the value stable takes at the next edge.
module key_debounce #(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic commit,
    output logic stable,
    output logic stable_next
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_SCANS - 1);

    logic [3:0] cnt;
    logic [3:0] cnt_next;

    always_comb begin
        stable_next = stable;
        cnt_next    = cnt;
        if (commit) begin
            if (raw == stable) begin
                cnt_next = '0;
            end else if (cnt == CNT_LAST) begin
                stable_next = ~stable;
                cnt_next    = '0;
            end else begin
                cnt_next = cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            stable <= stable_next;
            cnt    <= cnt_next;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: drives one row at a time, samples synchronised columns,
// and commits a debounced 16-bit key map once per frame.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    output logic [15:0] keypad_matrix,
    output logic        scan_done,
    output logic        any_pressed
);

    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_ROW    = 2'(NUM_ROWS - 1);

    scan_state_t state;
    logic [1:0]  row;
    logic [9:0]  settle_cnt;
    logic [3:0]  col_meta;
    logic [3:0]  col_sync;
    logic [15:0] raw;
    logic [15:0] raw_hex;
    logic [15:0] stable_next;
    logic        commit;

    assign commit = (state == COMMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= DRIVE;
            row        <= '0;
            settle_cnt <= '0;
            raw        <= '0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= commit;
            case (state)
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 10'd1;
                    end
                end
                SAMPLE: begin
                    raw[{row, 2'b00} +: 4] <= ~col_sync;
                    if (row == LAST_ROW) begin
                        state <= COMMIT;
                    end else begin
                        row   <= row + 2'd1;
                        state <= DRIVE;
                    end
                end
                COMMIT: begin
                    row   <= '0;
                    state <= DRIVE;
                end
                default: state <= DRIVE;
            endcase
        end
    end

    // Gated by reset so the rows release immediately, before any clock edge.
    always_comb begin
        row_n = '1;
        if (!reset && state != COMMIT) begin
            row_n[row] = 1'b0;
        end
    end

    always_comb begin
        raw_hex = '0;
        for (int unsigned p = 0; p < NUM_KEYS; p++) begin
            raw_hex[KEY_MAP[p[3:0]]] = raw[p[3:0]];
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_key (
            .clk        (clk),
            .reset      (reset),
            .raw        (raw_hex[k]),
            .commit     (commit),
            .stable     (keypad_matrix[k]),
            .stable_next(stable_next[k])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |stable_next;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: behavioural keypad drives col_n from row_n,
// a frame-level debounce model predicts keypad_matrix after every scan_done.
module tb_keypad_scanner;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEB    = 3;
    localparam int unsigned FRAME  = 4 * (SETTLE + 1) + 1;

    // Hex key at physical index 4*row + col.
    localparam int HEX [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keypad_matrix;
    logic        scan_done;
    logic        any_pressed;

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .row_n        (row_n),
        .col_n        (col_n),
        .keypad_matrix(keypad_matrix),
        .scan_done    (scan_done),
        .any_pressed  (any_pressed)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] held;
    logic [15:0] cur_held;
    logic [15:0] model_q;
    int          streak [16];
    int          tests = 0;
    int          fails = 0;
    int unsigned last_done;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (row_n[r] == 1'b0) begin
                for (int c = 0; c < 4; c++) begin
                    if (held[HEX[r * 4 + c]]) col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_q = '0;
        for (int k = 0; k < 16; k++) streak[k] = 0;
    endtask

    // A key flips once it has disagreed with its stable value for DEB frames in a row.
    task automatic model_commit(input logic [15:0] frame_raw);
        for (int k = 0; k < 16; k++) begin
            if (frame_raw[k] != model_q[k]) begin
                streak[k]++;
                if (streak[k] == DEB) begin
                    model_q[k] = ~model_q[k];
                    streak[k]  = 0;
                end
            end else begin
                streak[k] = 0;
            end
        end
    endtask

    task automatic commit_frame(input logic [15:0] next_held);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
            if (!scan_done) check("hold", 32'(keypad_matrix), 32'(model_q));
        end while (!scan_done && n < 2 * FRAME);
        tests++;
        assert (scan_done === 1'b1) else begin
            fails++;
            $error("FAIL scan_done_timeout: observed %b expected 1", scan_done);
        end
        check("period", cyc - last_done, FRAME);
        last_done = cyc;
        model_commit(cur_held);
        check("matrix", 32'(keypad_matrix), 32'(model_q));
        check("any_pressed", 32'(any_pressed), 32'(model_q != 16'h0));
        held     = next_held;
        cur_held = next_held;
    endtask

    logic [15:0] frame_held [23] = '{
        16'h0000, 16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000, 16'h0000,
        16'h0040, 16'h0040, 16'h0000, 16'h0040, 16'h0040, 16'h0000, 16'h0000,
        16'h8001, 16'h8001, 16'h8001, 16'h1000, 16'h1000, 16'h1000,
        16'h0040, 16'h0040, 16'h0040
    };
    logic [15:0] frame_exp [23] = '{
        16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0040, 16'h0040, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
        16'h0000, 16'h0000, 16'h8001, 16'h8001, 16'h8001, 16'h1000,
        16'h1000, 16'h1000, 16'h0040
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_row;
        logic [15:0] nh;
        int          n;

        reset    = 1'b1;
        held     = '0;
        cur_held = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_row_n", 32'(row_n), 32'hF);
        check("reset_matrix", 32'(keypad_matrix), 32'h0);
        check("reset_scan_done", 32'(scan_done), 32'h0);
        check("reset_any", 32'(any_pressed), 32'h0);

        @(negedge clk);
        reset     = 1'b0;
        last_done = cyc;
        #1;
        for (int i = 0; i < 20; i++) begin
            exp_row = ~(4'b0001 << (i / 5));
            check("row_seq", 32'(row_n), 32'(exp_row));
            check("seq_scan_done", 32'(scan_done), 32'h0);
            @(negedge clk);
            #1;
        end
        check("row_commit", 32'(row_n), 32'hF);

        for (int i = 0; i < 23; i++) begin
            commit_frame((i < 22) ? frame_held[i + 1] : 16'h0040);
            check("directed", 32'(keypad_matrix), 32'(frame_exp[i]));
        end

        // Key 6 is stable; interrupt the next frame while row 2 is driven.
        n = 0;
        while (row_n !== 4'b1011 && n < 2 * FRAME) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_row2", 32'(row_n), 32'hB);
        reset = 1'b1;
        #1;
        check("midreset_matrix", 32'(keypad_matrix), 32'h0);
        check("midreset_row_n", 32'(row_n), 32'hF);
        check("midreset_any", 32'(any_pressed), 32'h0);
        check("midreset_scan_done", 32'(scan_done), 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        last_done = cyc;
        model_reset();
        #1;
        check("restart_row0", 32'(row_n), 32'hE);
        for (int i = 0; i < 3; i++) commit_frame(16'h0040);
        check("restart_key6", 32'(keypad_matrix), 32'h0040);

        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 3))
                0, 1:    nh = cur_held;
                2:       nh = cur_held ^ (16'h1 << $urandom_range(0, 15));
                default: nh = 16'($urandom());
            endcase
            commit_frame(nh);
        end
        commit_frame(16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
